// File: rtl/ili9341_spi_engine_pkg.sv
// Shared types and ILI9341 command opcodes for the SPI engine and its sequencers.
package pkg_ili9341;

    typedef enum logic [2:0] {
        RST_LO,
        RST_WAIT,
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_RDDID   = 8'h04;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

endpackage

// File: rtl/ili9341_spi_engine_clk_div.sv
// Half-period tick generator: tick is high on the last clk of each sclk half-period.
module spi_clk_div
    import pkg_ili9341::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DVW-1:0] cnt;

    assign tick = en && (cnt == DVW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == DVW'(CLK_DIV - 1)) ? '0 : cnt + DVW'(1);
        end
    end

endmodule

// File: rtl/ili9341_spi_engine.sv
// SPI mode-0 command/data engine for the ILI9341 panel with burst framing,
// optional MISO register reads and the panel hardware-reset sequence.
module ili9341_spi_engine
    import pkg_ili9341::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DW           = 8,
    parameter int RST_LOW_CYC  = 10000,
    parameter int RST_WAIT_CYC = 120000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_dc,
    input  logic          in_last,
    input  logic          in_rd,
    input  logic          hw_reset_req,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy,
    input  logic          miso,
    output logic          mosi,
    output logic          sclk,
    output logic          dc,
    output logic          cs,
    output logic          lcd_rst_n
);

    localparam int RST_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int RCW     = $clog2(RST_MAX + 1);
    localparam int BCW     = $clog2(DW + 1);

    spi_state_e      state;
    logic [RCW-1:0]  rcnt;
    logic [BCW-1:0]  bcnt;
    logic            ph;
    logic            last_q;
    logic            rd_q;
    logic [DW-2:0]   tx;
    logic [DW-1:0]   rx;
    logic            tick;
    logic            accept;
    logic            div_en;
    logic            rise_evt;
    logic            fall_evt;
    logic            word_done;

    assign in_ready  = ((state == IDLE) && !hw_reset_req) || ((state == HOLD) && !last_q);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign div_en    = (state == SHIFT) || (state == HOLD) || (state == GAP);
    assign rise_evt  = (state == SHIFT) && tick && !ph;
    assign fall_evt  = (state == SHIFT) && tick && ph;
    assign word_done = fall_evt && (bcnt == BCW'(DW - 1));

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_LO;
            rcnt      <= '0;
            bcnt      <= '0;
            ph        <= 1'b0;
            last_q    <= 1'b0;
            rd_q      <= 1'b0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            dc        <= 1'b0;
            lcd_rst_n <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                // Same entry path from IDLE and from a non-last HOLD, so cs never blips inside a burst
                state  <= SHIFT;
                bcnt   <= '0;
                ph     <= 1'b0;
                cs     <= 1'b0;
                sclk   <= 1'b0;
                dc     <= in_dc;
                last_q <= in_last;
                rd_q   <= in_rd;
                mosi   <= !in_rd && in_data[DW-1];
            end else begin
                case (state)
                    RST_LO: begin
                        if (rcnt == RCW'(RST_LOW_CYC - 1)) begin
                            state     <= RST_WAIT;
                            rcnt      <= '0;
                            lcd_rst_n <= 1'b1;
                        end else begin
                            rcnt <= rcnt + RCW'(1);
                        end
                    end
                    RST_WAIT: begin
                        if (rcnt == RCW'(RST_WAIT_CYC - 1)) begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + RCW'(1);
                        end
                    end
                    IDLE: begin
                        if (hw_reset_req) begin
                            state     <= RST_LO;
                            rcnt      <= '0;
                            lcd_rst_n <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (rise_evt) begin
                            sclk <= 1'b1;
                            ph   <= 1'b1;
                        end else if (fall_evt) begin
                            sclk <= 1'b0;
                            ph   <= 1'b0;
                            if (word_done) begin
                                state     <= HOLD;
                                mosi      <= 1'b0;
                                out_valid <= rd_q;
                                if (rd_q) begin
                                    out_data <= rx;
                                end
                            end else begin
                                bcnt <= bcnt + BCW'(1);
                                mosi <= tx[DW-2];
                            end
                        end
                    end
                    HOLD: begin
                        if (last_q && tick) begin
                            cs    <= 1'b1;
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= RST_LO;
                endcase
            end
        end
    end

    // Shift registers carry no reset: they are always reloaded on accept before use
    always_ff @(posedge clk) begin
        if (accept) begin
            tx <= in_rd ? '0 : in_data[DW-2:0];
        end else if (fall_evt) begin
            tx <= tx << 1;
        end
        if (rise_evt) begin
            rx <= {rx[DW-2:0], miso};
        end
    end

endmodule

// File: tb/tb_ili9341_spi_engine.sv
// Directed bench for ili9341_spi_engine: 8-bit and 16-bit instances, CLK_DIV=2.
module tb_ili9341_spi_engine;
    import pkg_ili9341::*;

    localparam int CD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv8, ir8, dc_in8, last8, rd8, hwr8, ov8, miso8, mosi8, sclk8, dc8, cs8, lrn8, busy8;
    logic [7:0] id8, od8;
    logic        iv16, ir16, dc_in16, last16, rd16, hwr16, ov16, miso16, mosi16, sclk16, dc16, cs16, lrn16, busy16;
    logic [15:0] id16, od16;

    ili9341_spi_engine #(.CLK_DIV(CD), .DW(8), .RST_LOW_CYC(10), .RST_WAIT_CYC(20)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_dc(dc_in8),
        .in_last(last8), .in_rd(rd8), .hw_reset_req(hwr8), .out_valid(ov8), .out_data(od8),
        .busy(busy8), .miso(miso8), .mosi(mosi8), .sclk(sclk8), .dc(dc8), .cs(cs8), .lcd_rst_n(lrn8)
    );

    ili9341_spi_engine #(.CLK_DIV(CD), .DW(16), .RST_LOW_CYC(10), .RST_WAIT_CYC(20)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_dc(dc_in16),
        .in_last(last16), .in_rd(rd16), .hw_reset_req(hwr16), .out_valid(ov16), .out_data(od16),
        .busy(busy16), .miso(miso16), .mosi(mosi16), .sclk(sclk16), .dc(dc16), .cs(cs16), .lcd_rst_n(lrn16)
    );

    // Panel read model: next bit presented after each sclk fall, MSB first
    logic [7:0] rd_pat = 8'h00;
    int         fall_cnt = 0;
    int         fall_base = 0;
    always @(negedge sclk8) fall_cnt = fall_cnt + 1;
    assign miso8  = rd_pat[3'(7 - (fall_cnt - fall_base))];
    assign miso16 = 1'b0;

    logic sel;
    logic m_sclk, m_mosi, m_cs, m_dc, m_ov, m_ready, m_busy;
    always_comb begin
        m_sclk  = sel ? sclk16 : sclk8;
        m_mosi  = sel ? mosi16 : mosi8;
        m_cs    = sel ? cs16   : cs8;
        m_dc    = sel ? dc16   : dc8;
        m_ov    = sel ? ov16   : ov8;
        m_ready = sel ? ir16   : ir8;
        m_busy  = sel ? busy16 : busy8;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [15:0] cap;
    int rises, first_rise, cs_hi, dc_bad, mosi_hi, ov_win;
    logic ov_entry, sclk_entry;

    // Called at a negedge; returns at the sample of HOLD entry
    task automatic send(input int dw, input logic [15:0] d, input logic dcv, input logic lastv,
                        input logic rdv, input logic hwr_mid);
        int n;
        logic prev;
        sel = (dw == 16);
        if (sel) begin
            id16 = d; dc_in16 = dcv; last16 = lastv; rd16 = rdv; iv16 = 1'b1;
        end else begin
            id8 = d[7:0]; dc_in8 = dcv; last8 = lastv; rd8 = rdv; iv8 = 1'b1;
        end
        #1;
        n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 200), 1);
        @(negedge clk);
        iv8 = 1'b0;
        iv16 = 1'b0;
        cap = '0; rises = 0; first_rise = 0; cs_hi = 0; dc_bad = 0; mosi_hi = 0; ov_win = 0;
        prev = 1'b0;
        for (int i = 1; i <= 2 * dw * CD; i++) begin
            if (m_sclk && !prev) begin
                rises++;
                cap = {cap[14:0], m_mosi};
                if (first_rise == 0) first_rise = i;
            end
            cs_hi   += int'(m_cs);
            dc_bad  += int'(m_dc !== dcv);
            mosi_hi += int'(m_mosi);
            ov_win  += int'(m_ov);
            prev = m_sclk;
            if (hwr_mid && i == 5) hwr8 = 1'b1;
            if (hwr_mid && i == 9) hwr8 = 1'b0;
            @(negedge clk);
        end
        ov_entry   = m_ov;
        sclk_entry = m_sclk;
    endtask

    task automatic frame_checks(input string t, input int dw, input logic [15:0] d);
        check({t, "_bits"}, 32'(cap), 32'(d));
        check({t, "_rises"}, rises, dw);
        check({t, "_first_rise"}, first_rise, 1 + CD);
        check({t, "_cs_high_in_word"}, cs_hi, 0);
        check({t, "_dc_wrong"}, dc_bad, 0);
        check({t, "_sclk_at_hold"}, 32'(sclk_entry), 0);
    endtask

    // From HOLD entry of a last word through GAP back to IDLE
    task automatic tail_last(input string t);
        check({t, "_hold_cs"}, 32'(m_cs), 0);
        check({t, "_hold_ready"}, 32'(m_ready), 0);
        @(negedge clk);
        check({t, "_hold2_cs"}, 32'(m_cs), 0);
        check({t, "_ov_once"}, 32'(m_ov), 0);
        @(negedge clk);
        check({t, "_gap_cs"}, 32'(m_cs), 1);
        check({t, "_gap_ready"}, 32'(m_ready), 0);
        check({t, "_gap_busy"}, 32'(m_busy), 1);
        @(negedge clk);
        check({t, "_gap2_busy"}, 32'(m_busy), 1);
        @(negedge clk);
        check({t, "_idle_busy"}, 32'(m_busy), 0);
        check({t, "_idle_ready"}, 32'(m_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lo, bz, rk, n, tot;
        iv8 = 0; id8 = '0; dc_in8 = 0; last8 = 0; rd8 = 0; hwr8 = 0;
        iv16 = 0; id16 = '0; dc_in16 = 0; last16 = 0; rd16 = 0; hwr16 = 0;
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_cs", 32'(cs8), 1);
        check("rst_sclk", 32'(sclk8), 0);
        check("rst_mosi", 32'(mosi8), 0);
        check("rst_dc", 32'(dc8), 0);
        check("rst_lcd_rst_n", 32'(lrn8), 0);
        check("rst_in_ready", 32'(ir8), 0);
        check("rst_out_valid", 32'(ov8), 0);
        check("rst_out_data", 32'(od8), 0);
        check("rst_busy", 32'(busy8), 1);

        rst = 1'b0;
        lo = 0; bz = 0; rk = -1;
        for (int k = 0; k < 40; k++) begin
            if (!lrn8) lo++;
            if (busy8) bz++;
            if (ir8 && rk < 0) rk = k;
            @(negedge clk);
        end
        check("rst_low_cycles", lo, 10);
        check("busy_cycles", bz, 30);
        check("ready_cycle", rk + 1, 31);
        check("rst16_released", 32'(lrn16), 1);

        // Single command write
        send(8, {8'h00, CMD_CASET}, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_checks("caset", 8, 16'h002A);
        check("caset_no_ov", 32'(ov_entry), 0);
        tail_last("caset");

        // Burst under one chip-select
        tot = 0;
        send(8, {8'h00, CMD_RAMWR}, 1'b0, 1'b0, 1'b0, 1'b0);
        frame_checks("burst0", 8, 16'h002C);
        tot += rises;
        check("burst0_hold_ready", 32'(ir8), 1);
        check("burst0_hold_cs", 32'(cs8), 0);
        send(8, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        frame_checks("burst1", 8, 16'h0000);
        tot += rises;
        check("burst1_hold_cs", 32'(cs8), 0);
        send(8, 16'h001F, 1'b1, 1'b1, 1'b0, 1'b0);
        frame_checks("burst2", 8, 16'h001F);
        tot += rises;
        check("burst_total_rises", tot, 24);
        tail_last("burst2");

        // Register read: command then read word
        send(8, {8'h00, CMD_RDDID}, 1'b0, 1'b0, 1'b0, 1'b0);
        frame_checks("rddid", 8, 16'h0004);
        rd_pat = 8'hA5;
        fall_base = fall_cnt;
        send(8, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0);
        check("read_rises", rises, 8);
        check("read_mosi_high", mosi_hi, 0);
        check("read_ov_early", ov_win, 0);
        check("read_ov_entry", 32'(ov_entry), 1);
        check("read_data", 32'(od8), 32'h00A5);
        tail_last("read");
        rd_pat = 8'h00;

        // A write must leave out_data alone
        send(8, {8'h00, CMD_SLPOUT}, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_checks("slpout", 8, 16'h0011);
        check("slpout_ov", 32'(ov_win) + 32'(ov_entry), 0);
        check("slpout_data_held", 32'(od8), 32'h00A5);
        tail_last("slpout");

        // 16-bit pixel word
        send(16, 16'hF800, 1'b1, 1'b1, 1'b0, 1'b0);
        frame_checks("pix16", 16, 16'hF800);
        check("pix16_ones", $countones(cap), 5);
        check("pix16_out_data", 32'(od16), 0);
        tail_last("pix16");
        sel = 1'b0;

        // hw_reset_req while shifting is ignored
        send(8, {8'h00, CMD_DISPON}, 1'b0, 1'b1, 1'b0, 1'b1);
        frame_checks("dispon", 8, 16'h0029);
        check("dispon_lcd_rst_n", 32'(lrn8), 1);
        tail_last("dispon");

        // hw_reset_req beats in_valid in IDLE
        hwr8 = 1'b1; iv8 = 1'b1; id8 = CMD_SWRESET; dc_in8 = 1'b0; last8 = 1'b1; rd8 = 1'b0;
        #1;
        check("hwreq_ready", 32'(ir8), 0);
        @(negedge clk);
        check("hwreq_lcd_rst_n", 32'(lrn8), 0);
        check("hwreq_busy", 32'(busy8), 1);
        check("hwreq_cs", 32'(cs8), 1);
        hwr8 = 1'b0; iv8 = 1'b0;
        n = 0;
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hwreq_seq_len", n, 30);

        // rst in the middle of a word
        id8 = CMD_PASET; dc_in8 = 1'b1; last8 = 1'b1; rd8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_sclk_before", 32'(sclk8), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", 32'(cs8), 1);
        check("midrst_sclk", 32'(sclk8), 0);
        check("midrst_mosi", 32'(mosi8), 0);
        check("midrst_dc", 32'(dc8), 0);
        check("midrst_busy", 32'(busy8), 1);
        check("midrst_lcd_rst_n", 32'(lrn8), 0);
        rst = 1'b0;
        n = 0;
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_seq_len", n, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
